// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg: opcodes, controller states and counter sizing shared by the ALU request arbiter
package alu_ctrl_pkg;
  typedef enum logic [3:0] {
    FUN_ADD, FUN_SUB, FUN_MUL, FUN_DIV, FUN_AND, FUN_OR, FUN_XOR, FUN_NAND,
    FUN_NOR, FUN_XNOR, FUN_NOT, FUN_INC, FUN_DEC, FUN_SHR, FUN_SHL, FUN_ILLEGAL
  } alu_fun_e;
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  function automatic int cnt_width(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/rr_arbiter.sv
// rr_arbiter: combinational round-robin pick, first set request at or above ptr (wrapping)
//   req: request vector, ptr: search start, gnt: one-hot grant, idx: encoded winner, any: some request set
module rr_arbiter #(
  parameter int NUM_REQ = 2,
  parameter int IW = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IW-1:0]      ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IW-1:0]      idx,
  output logic               any
);
  always_comb begin
    idx = '0;
    // descending scan so the nearest request to ptr is written last and wins
    for (int i = NUM_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % NUM_REQ]) idx = IW'((int'(ptr) + i) % NUM_REQ);
  end
  assign any = |req;
  assign gnt = any ? NUM_REQ'(1) << idx : '0;
endmodule

// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter: round-robin sharing of one registered ALU among NUM_REQ requesters
//   REQ_*: packed per-requester request, operands and opcode; REQ_READY: one-hot grant
//   RSP_*: one-hot response pulse with shared result and error flag
//   ALU_*: operands, opcode, enable and clock-gate enable to the ALU; ALU_OUT(_VALID): its result
module alu_req_arbiter
  import alu_ctrl_pkg::*;
#(
  parameter int OPER_WIDTH = 8,
  parameter int OUT_WIDTH = 2 * OPER_WIDTH,
  parameter int NUM_REQ = 2,
  parameter int WAIT_MAX = 4
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [NUM_REQ-1:0]            REQ_VALID,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] REQ_A,
  input  logic [NUM_REQ*OPER_WIDTH-1:0] REQ_B,
  input  logic [NUM_REQ*4-1:0]          REQ_FUN,
  output logic [NUM_REQ-1:0]            REQ_READY,
  output logic [NUM_REQ-1:0]            RSP_VALID,
  output logic [OUT_WIDTH-1:0]          RSP_DATA,
  output logic                          RSP_ERR,
  output logic [OPER_WIDTH-1:0]         ALU_A,
  output logic [OPER_WIDTH-1:0]         ALU_B,
  output logic [3:0]                    ALU_FUN,
  output logic                          ALU_EN,
  output logic                          ALU_CLK_EN,
  input  logic [OUT_WIDTH-1:0]          ALU_OUT,
  input  logic                          ALU_OUT_VALID
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = cnt_width(WAIT_MAX);
  state_e state;
  logic [IW-1:0] ptr, id, win;
  logic [NUM_REQ-1:0] gnt;
  logic [CW-1:0] cnt;
  logic any, start, bad;
  logic [OPER_WIDTH-1:0] a_sel, b_sel;
  logic [3:0] fun_sel;
  rr_arbiter #(.NUM_REQ(NUM_REQ), .IW(IW)) u_rr (
    .req(REQ_VALID), .ptr(ptr), .gnt(gnt), .idx(win), .any(any)
  );
  assign a_sel = REQ_A[int'(win)*OPER_WIDTH +: OPER_WIDTH];
  assign b_sel = REQ_B[int'(win)*OPER_WIDTH +: OPER_WIDTH];
  assign fun_sel = REQ_FUN[int'(win)*4 +: 4];
  assign bad = fun_sel == FUN_ILLEGAL || (fun_sel == FUN_DIV && b_sel == '0);
  assign start = state == IDLE && any && !RST;
  assign REQ_READY = start ? gnt : '0;
  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      ptr <= '0;
      id <= '0;
      cnt <= '0;
      RSP_VALID <= '0;
      RSP_DATA <= '0;
      RSP_ERR <= 1'b0;
      ALU_A <= '0;
      ALU_B <= '0;
      ALU_FUN <= '0;
      ALU_EN <= 1'b0;
      ALU_CLK_EN <= 1'b0;
    end else begin
      RSP_VALID <= '0;
      ALU_EN <= 1'b0;
      case (state)
        IDLE: if (start) begin
          ALU_A <= a_sel;
          ALU_B <= b_sel;
          ALU_FUN <= fun_sel;
          id <= win;
          ptr <= win == IW'(NUM_REQ - 1) ? '0 : win + 1'b1;
          if (bad) begin
            // screened reject answers directly without touching the ALU
            state <= RESP;
            RSP_VALID <= gnt;
            RSP_DATA <= '0;
            RSP_ERR <= 1'b1;
          end else begin
            state <= ISSUE;
            ALU_EN <= 1'b1;
            ALU_CLK_EN <= 1'b1;
          end
        end
        ISSUE: begin
          state <= WAIT;
          cnt <= '0;
        end
        WAIT: if (ALU_OUT_VALID || cnt == CW'(WAIT_MAX - 1)) begin
          state <= RESP;
          RSP_VALID <= NUM_REQ'(1) << id;
          RSP_DATA <= ALU_OUT_VALID ? ALU_OUT : '0;
          RSP_ERR <= !ALU_OUT_VALID;
          ALU_CLK_EN <= 1'b0;
        end else cnt <= cnt + 1'b1;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_alu_req_arbiter.sv
// tb_alu_req_arbiter: scoreboard-based bench for alu_req_arbiter with a behavioural 1-cycle ALU
module tb_alu_req_arbiter;
  import alu_ctrl_pkg::*;
  typedef struct {
    int r;
    logic [15:0] d;
    logic e;
  } exp_t;
  logic clk = 1'b0;
  logic rst;
  logic [1:0] req_valid;
  logic [15:0] req_a, req_b;
  logic [7:0] req_fun;
  logic [1:0] req_ready, rsp_valid;
  logic [15:0] rsp_data, alu_out;
  logic rsp_err, alu_en, alu_clk_en, alu_vld, alu_on, spur;
  logic [7:0] alu_a, alu_b;
  logic [3:0] alu_fun;
  exp_t sb[$];
  int total = 0;
  int bad = 0;
  always #5 clk = ~clk;
  alu_req_arbiter dut (
    .CLK(clk), .RST(rst), .REQ_VALID(req_valid), .REQ_A(req_a), .REQ_B(req_b),
    .REQ_FUN(req_fun), .REQ_READY(req_ready), .RSP_VALID(rsp_valid), .RSP_DATA(rsp_data),
    .RSP_ERR(rsp_err), .ALU_A(alu_a), .ALU_B(alu_b), .ALU_FUN(alu_fun), .ALU_EN(alu_en),
    .ALU_CLK_EN(alu_clk_en), .ALU_OUT(alu_out), .ALU_OUT_VALID(alu_vld | spur)
  );
  function automatic logic [15:0] alu_model(input logic [3:0] f, input logic [7:0] a, b);
    case (f)
      4'd0: return {8'h00, a} + {8'h00, b};
      4'd1: return {8'h00, a} - {8'h00, b};
      4'd2: return {8'h00, a} * {8'h00, b};
      4'd3: return {8'h00, a / b};
      default: return 16'h0;
    endcase
  endfunction
  always_ff @(posedge clk) begin
    alu_vld <= alu_en && alu_on;
    if (alu_en) alu_out <= alu_model(alu_fun, alu_a, alu_b);
  end
  task automatic pop_check(input string nm, input int r);
    exp_t e;
    total++;
    if (sb.size() == 0) begin
      bad++;
      $display("FAIL %s: response with empty scoreboard got=%0h", nm, rsp_valid);
    end else begin
      e = sb.pop_front();
      if (rsp_data !== e.d || rsp_err !== e.e || r !== e.r) begin
        bad++;
        $display("FAIL %s: got r=%0d d=%h e=%b exp r=%0d d=%h e=%b", nm, r, rsp_data, rsp_err, e.r, e.d, e.e);
      end
    end
  endtask
  task automatic run_one(input string nm, input int r, input logic [7:0] a, b,
                         input logic [3:0] f, input int lat, input logic [15:0] ed, input logic ee);
    logic [1:0] oh;
    logic rej, got;
    oh = 2'b01 << r;
    rej = lat == 1;
    got = 1'b0;
    req_a[r*8 +: 8] = a;
    req_b[r*8 +: 8] = b;
    req_fun[r*4 +: 4] = f;
    req_valid = oh;
    #1;
    total++;
    if (req_ready !== oh) begin
      bad++;
      $display("FAIL %s_ready: got=%b exp=%b", nm, req_ready, oh);
    end
    sb.push_back('{r, ed, ee});
    for (int k = 1; k <= 12 && !got; k++) begin
      @(negedge clk);
      if (k == 1) req_valid = 2'b00;
      total++;
      if (alu_en !== (!rej && k == 1)) begin
        bad++;
        $display("FAIL %s_alu_en: cycle %0d got=%b", nm, k, alu_en);
      end
      if (k <= lat) begin
        total++;
        if (alu_clk_en !== (!rej && k < lat)) begin
          bad++;
          $display("FAIL %s_clk_en: cycle %0d got=%b", nm, k, alu_clk_en);
        end
      end
      if (k == 1 && !rej) begin
        total++;
        if (alu_a !== a || alu_b !== b || alu_fun !== f) begin
          bad++;
          $display("FAIL %s_operands: got=%h/%h/%h exp=%h/%h/%h", nm, alu_a, alu_b, alu_fun, a, b, f);
        end
      end
      if (rsp_valid !== 2'b00) begin
        got = 1'b1;
        total++;
        if (k != lat || rsp_valid !== oh) begin
          bad++;
          $display("FAIL %s_latency: got cycle=%0d valid=%b exp cycle=%0d valid=%b", nm, k, rsp_valid, lat, oh);
        end
        pop_check(nm, r);
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("FAIL %s_timeout: no response within 12 cycles, exp cycle=%0d", nm, lat);
    end
  endtask
  task automatic check_idle_zero(input string nm);
    total++;
    if ({req_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_fun, alu_en, alu_clk_en} !== '0) begin
      bad++;
      $display("FAIL %s: got ready=%b valid=%b data=%h err=%b a=%h b=%h fun=%h en=%b cen=%b exp all zero",
               nm, req_ready, rsp_valid, rsp_data, rsp_err, alu_a, alu_b, alu_fun, alu_en, alu_clk_en);
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_idle_zero("reset");
  endtask
  task automatic test_single();
    run_one("single", 0, 8'h12, 8'h34, FUN_ADD, 3, 16'h0046, 1'b0);
  endtask
  task automatic test_div_zero();
    run_one("divzero", 1, 8'h40, 8'h00, FUN_DIV, 1, 16'h0000, 1'b1);
    @(negedge clk);
    run_one("illegal", 0, 8'h01, 8'h02, FUN_ILLEGAL, 1, 16'h0000, 1'b1);
    @(negedge clk);
    run_one("div", 1, 8'h40, 8'h08, FUN_DIV, 3, 16'h0008, 1'b0);
  endtask
  task automatic expect_ready(input string nm, input logic [1:0] exp);
    #1;
    total++;
    if (req_ready !== exp) begin
      bad++;
      $display("FAIL %s: got=%b exp=%b", nm, req_ready, exp);
    end
  endtask
  task automatic expect_rsp(input string nm, input int r);
    logic [1:0] oh;
    oh = 2'b01 << r;
    total++;
    if (rsp_valid !== oh) begin
      bad++;
      $display("FAIL %s_valid: got=%b exp=%b", nm, rsp_valid, oh);
    end else pop_check(nm, r);
  endtask
  task automatic test_contention();
    req_a = {8'h09, 8'h01};
    req_b = {8'h04, 8'h02};
    req_fun = {4'(FUN_SUB), 4'(FUN_ADD)};
    req_valid = 2'b11;
    expect_ready("cont_g0", 2'b01);
    sb.push_back('{0, 16'h0003, 1'b0});
    @(negedge clk);
    req_valid = 2'b10;
    expect_ready("cont_busy", 2'b00);
    repeat (2) @(negedge clk);
    expect_rsp("cont_r0", 0);
    @(negedge clk);
    expect_ready("cont_g1", 2'b10);
    sb.push_back('{1, 16'h0005, 1'b0});
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    expect_rsp("cont_r1", 1);
    @(negedge clk);
    req_valid = 2'b11;
    expect_ready("cont_g0_again", 2'b01);
    sb.push_back('{0, 16'h0003, 1'b0});
    @(negedge clk);
    req_valid = 2'b00;
    repeat (2) @(negedge clk);
    expect_rsp("cont_r0_again", 0);
    @(negedge clk);
  endtask
  task automatic test_timeout();
    alu_on = 1'b0;
    run_one("timeout", 0, 8'h05, 8'h06, FUN_ADD, 6, 16'h0000, 1'b1);
    alu_on = 1'b1;
    @(negedge clk);
  endtask
  task automatic test_reset_mid_wait();
    alu_on = 1'b0;
    req_a[7:0] = 8'h11;
    req_b[7:0] = 8'h22;
    req_fun[3:0] = FUN_ADD;
    req_valid = 2'b01;
    expect_ready("rstwait_ready", 2'b01);
    @(negedge clk);
    req_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("rstwait_zero");
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00) begin
        bad++;
        $display("FAIL rstwait_norsp: cycle %0d got=%b exp=00", k, rsp_valid);
      end
    end
    alu_on = 1'b1;
    run_one("mul", 0, 8'hFF, 8'hFF, FUN_MUL, 3, 16'hFE01, 1'b0);
    @(negedge clk);
  endtask
  task automatic test_spurious();
    spur = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      total++;
      if (rsp_valid !== 2'b00 || rsp_data !== 16'hFE01) begin
        bad++;
        $display("FAIL spurious: got valid=%b data=%h exp valid=00 data=fe01", rsp_valid, rsp_data);
      end
    end
    spur = 1'b0;
    @(negedge clk);
    run_one("after_spur", 1, 8'h80, 8'h80, FUN_ADD, 3, 16'h0100, 1'b0);
  endtask
  initial begin
    rst = 1'b1;
    req_valid = 2'b00;
    req_a = '0;
    req_b = '0;
    req_fun = '0;
    alu_on = 1'b1;
    spur = 1'b0;
    test_reset();
    test_single();
    @(negedge clk);
    test_div_zero();
    @(negedge clk);
    test_contention();
    test_timeout();
    test_reset_mid_wait();
    test_spurious();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL scoreboard_drain: got=%0d entries exp=0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
